m_display: RTL

- PicoBlaze output-port peripheral; the write-side counterpart of the keypad scanner.
- Drives a multiplexed 4-digit 7-segment+DP LED display: scans one digit strobe at a time and presents that digit's segment pattern.
- Provides per-digit PWM brightness, a blanking dead-slot between digits, and double-buffered frame commit so the CPU never shows torn frames.

---
 rtl/m_display.sv | 77 +++++++
 1 files changed

// File: rtl/m_display.sv
// m_display: PicoBlaze output peripheral scanning a 4-digit 7-segment display with PWM brightness and double-buffered frames
module m_display #(
    parameter int BASE     = 0,
    parameter int PRESCALE = 1023
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    output logic [7:0] SEG,
    output logic       DIG1,
    output logic       DIG2,
    output logic       DIG3,
    output logic       DIG4
);
    localparam int PW = $clog2(PRESCALE + 1) > 10 ? $clog2(PRESCALE + 1) : 10;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE);
    localparam logic [7:0] B = 8'(BASE);
    logic [PW-1:0] pcnt;
    logic [3:0] slot, bright;
    logic [1:0] digidx;
    logic [7:0] off;
    logic [7:0] sh [4];
    logic [7:0] act [4];
    logic en, pend, tick, boundary, on, wr, commit_wr, commit;
    assign off       = port_id - B;
    assign wr        = write_strobe && off < 8'd6;
    assign commit_wr = wr && off == 8'd5;
    assign tick      = pcnt == PMAX;
    assign boundary  = tick && digidx == 2'd3 && slot == 4'd15;
    // a COMMIT landing on the boundary itself waits for the following frame
    assign commit    = boundary && pend && !commit_wr;
    // slot 15 is the inter-digit dead time that suppresses ghosting
    assign on        = en && slot < bright && slot != 4'd15;
    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt   <= '0;
            slot   <= '0;
            digidx <= '0;
            en     <= 1'b0;
            bright <= '0;
            pend   <= 1'b0;
            SEG    <= '0;
            DIG1   <= 1'b0;
            DIG2   <= 1'b0;
            DIG3   <= 1'b0;
            DIG4   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sh[i]  <= '0;
                act[i] <= '0;
            end
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick) begin
                slot <= slot + 4'd1;
                if (slot == 4'd15)
                    digidx <= digidx + 2'd1;
            end
            if (wr && off < 8'd4)
                sh[off[1:0]] <= out_port;
            if (wr && off == 8'd4) begin
                en     <= out_port[0];
                bright <= out_port[7:4];
            end
            if (commit)
                for (int i = 0; i < 4; i++)
                    act[i] <= sh[i];
            pend <= commit_wr || (pend && !commit);
            SEG  <= on ? act[digidx] : 8'h00;
            DIG1 <= on && digidx == 2'd0;
            DIG2 <= on && digidx == 2'd1;
            DIG3 <= on && digidx == 2'd2;
            DIG4 <= on && digidx == 2'd3;
        end
    end
endmodule
